// File: rtl/spdif_pkg.sv
// spdif_pkg: shared constants for the S/PDIF frame transmitter.
//   - Preamble cell patterns (MSB = first cell), written for a preceding line level of 0.
//   - Slot indices inside a 32-slot subframe word.
//   - FSM state encoding.
package spdif_pkg;

    localparam logic [7:0] PRE_B = 8'b1110_1000;
    localparam logic [7:0] PRE_M = 8'b1110_0010;
    localparam logic [7:0] PRE_W = 8'b1110_0100;

    localparam logic [4:0] SLOT_AUDIO_LO = 5'd4;
    localparam logic [4:0] SLOT_V        = 5'd28;
    localparam logic [4:0] SLOT_U        = 5'd29;
    localparam logic [4:0] SLOT_C        = 5'd30;
    localparam logic [4:0] SLOT_P        = 5'd31;

    typedef enum logic [2:0] {
        StIdle,
        StPreL,
        StDataL,
        StPreR,
        StDataR
    } state_e;

endpackage

// File: rtl/spdif_frame_tx_if.sv
// spdif_frame_tx_if: frame handshake and line outputs of the S/PDIF transmitter.
//   en_i          transmit enable
//   l_i / r_i     left / right sample, DATA_W bits, two's complement
//   valid_i       l_i/r_i valid
//   ready_o       one-cycle strobe: frame sampled this cycle
//   spdif_o       biphase-mark line output
//   block_start_o pulse on the first cell of a B preamble
//   underrun_o    pulse when ready_o fires with valid_i low
// Modports: master = sample source, slave = transmitter.
interface spdif_frame_tx_if #(
    parameter int unsigned DATA_W = 24
) ();

    logic              en_i;
    logic [DATA_W-1:0] l_i;
    logic [DATA_W-1:0] r_i;
    logic              valid_i;
    logic              ready_o;
    logic              spdif_o;
    logic              block_start_o;
    logic              underrun_o;

    modport master (
        output en_i, l_i, r_i, valid_i,
        input  ready_o, spdif_o, block_start_o, underrun_o
    );

    modport slave (
        input  en_i, l_i, r_i, valid_i,
        output ready_o, spdif_o, block_start_o, underrun_o
    );

endinterface

// File: rtl/spdif_subframe_enc.sv
// spdif_subframe_enc: combinational build of one 32-slot subframe word.
//   audio_i  24-bit MSB-aligned sample, placed LSB first into slots 4..27
//   v_i      validity bit (slot 28)
//   c_i      channel-status bit (slot 30)
//   word_o   slots 0..31; slots 0..3 (preamble) are 0, slot 29 (U) is 0,
//            slot 31 carries even parity over slots 4..31
module spdif_subframe_enc
    import spdif_pkg::*;
(
    input  logic [23:0] audio_i,
    input  logic        v_i,
    input  logic        c_i,
    output logic [31:0] word_o
);

    always_comb begin
        word_o                        = '0;
        word_o[SLOT_AUDIO_LO +: 24]   = audio_i;
        word_o[SLOT_V]                = v_i;
        word_o[SLOT_U]                = 1'b0;
        word_o[SLOT_C]                = c_i;
        word_o[SLOT_P]                = ^word_o[SLOT_C:SLOT_AUDIO_LO];
    end

endmodule

// File: rtl/spdif_frame_tx.sv
// spdif_frame_tx: S/PDIF (IEC 60958) transmitter. Takes stereo PCM frames over a
// valid/ready strobe and drives a registered biphase-mark line with B/M/W preambles,
// 192-frame block framing, V/U/C/P slots and even parity.
//   clk     transmit clock (cell rate x CELL_DIV)
//   rst_n   asynchronous active-low reset
//   bus     spdif_frame_tx_if.slave: en_i, l_i, r_i, valid_i in;
//           ready_o, spdif_o, block_start_o, underrun_o out
// Build option: define SPDIF_TX_CSTAT_EN to send CSTAT[n] in the C slot of frame n (n < 32);
// otherwise C is always 0 and CSTAT is unused.
module spdif_frame_tx
    import spdif_pkg::*;
#(
    parameter int unsigned DATA_W       = 24,
    parameter int unsigned CELL_DIV     = 1,
    parameter int unsigned BLOCK_FRAMES = 192,
    parameter logic [31:0] CSTAT        = 32'h0000_0200
) (
    input  logic           clk,
    input  logic           rst_n,
    spdif_frame_tx_if.slave bus
);

    localparam int unsigned DivW = (CELL_DIV > 1) ? $clog2(CELL_DIV) : 1;
    localparam int unsigned FcW  = (BLOCK_FRAMES > 1) ? $clog2(BLOCK_FRAMES) : 1;

    state_e           state_q, state_d;
    logic [DivW-1:0]  div_q, div_d;
    logic [5:0]       cell_q, cell_d;      // cell within subframe, 0..7 preamble, 8..63 data
    logic [FcW-1:0]   frame_cnt_q, frame_cnt_d;
    logic             spdif_q, spdif_d;
    logic             block_start_q, block_start_d;
    logic             pre_inv_q, pre_inv_d; // line level seen when the current preamble began
    logic [23:0]      l_q, l_d, r_q, r_d;
    logic             v_q, v_d;
    logic             run_ok_q;            // keeps ready_o low until one clock after reset

    logic             tick;
    logic             ready;
    logic             load_cell;
    logic             c_bit;
    logic [31:0]      word_l, word_r, word;
    logic [7:0]       pat;
    logic             inv;

    assign tick = (div_q == DivW'(CELL_DIV - 1));

`ifdef SPDIF_TX_CSTAT_EN
    logic [31:0] cstat_v;
    assign cstat_v = CSTAT;
    assign c_bit   = (32'(frame_cnt_q) < 32'd32) ? cstat_v[5'(frame_cnt_q)] : 1'b0;
`else
    logic unused_cstat;
    assign unused_cstat = ^CSTAT;
    assign c_bit        = 1'b0;
`endif

    spdif_subframe_enc u_enc_l (
        .audio_i (l_q),
        .v_i     (v_q),
        .c_i     (c_bit),
        .word_o  (word_l)
    );

    spdif_subframe_enc u_enc_r (
        .audio_i (r_q),
        .v_i     (v_q),
        .c_i     (c_bit),
        .word_o  (word_r)
    );

    always_comb begin
        state_d       = state_q;
        div_d         = div_q;
        cell_d        = cell_q;
        frame_cnt_d   = frame_cnt_q;
        spdif_d       = spdif_q;
        block_start_d = 1'b0;
        pre_inv_d     = pre_inv_q;
        l_d           = l_q;
        r_d           = r_q;
        v_d           = v_q;
        ready         = 1'b0;
        load_cell     = 1'b0;
        pat           = '0;
        word          = '0;
        inv           = 1'b0;

        if (state_q == StIdle) begin
            div_d  = '0;
            cell_d = '0;
            ready  = bus.en_i & run_ok_q;
        end else begin
            div_d = tick ? '0 : div_q + 1'b1;
            if (tick) begin
                load_cell = 1'b1;
                cell_d    = cell_q + 6'd1;
                unique case (state_q)
                    StPreL:  if (cell_q == 6'd7)  state_d = StDataL;
                    StDataL: if (cell_q == 6'd63) state_d = StPreR;
                    StPreR:  if (cell_q == 6'd7)  state_d = StDataR;
                    StDataR: begin
                        if (cell_q == 6'd63) begin
                            frame_cnt_d = (frame_cnt_q == FcW'(BLOCK_FRAMES - 1)) ?
                                          '0 : frame_cnt_q + 1'b1;
                            if (bus.en_i) ready   = 1'b1;
                            else          state_d = StIdle;
                        end
                    end
                    default: ;
                endcase
            end
        end

        // Frame capture; the first preamble cell is loaded on this same edge.
        if (ready) begin
            state_d   = StPreL;
            cell_d    = '0;
            div_d     = '0;
            load_cell = 1'b1;
            if (bus.valid_i) begin
                l_d = 24'(bus.l_i) << (24 - DATA_W);
                r_d = 24'(bus.r_i) << (24 - DATA_W);
                v_d = 1'b0;
            end else begin
                l_d = '0;
                r_d = '0;
                v_d = 1'b1;
            end
        end

        // Line level for the cell that starts on the next edge.
        if (load_cell) begin
            unique case (state_d)
                StPreL, StPreR: begin
                    inv       = (cell_d == 6'd0) ? spdif_q : pre_inv_q;
                    pre_inv_d = inv;
                    if (state_d == StPreR)       pat = PRE_W;
                    else if (frame_cnt_d == '0)  pat = PRE_B;
                    else                         pat = PRE_M;
                    pat           = pat << cell_d[2:0];
                    spdif_d       = pat[7] ^ inv;
                    block_start_d = (state_d == StPreL) && (cell_d == 6'd0) &&
                                    (frame_cnt_d == '0);
                end
                StDataL, StDataR: begin
                    word = (state_d == StDataL) ? word_l : word_r;
                    // Slot start always toggles; mid-slot toggles only for a 1.
                    spdif_d = cell_d[0] ? (spdif_q ^ word[cell_d[5:1]]) : ~spdif_q;
                end
                default: spdif_d = spdif_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            div_q         <= '0;
            cell_q        <= '0;
            frame_cnt_q   <= '0;
            spdif_q       <= 1'b0;
            block_start_q <= 1'b0;
            pre_inv_q     <= 1'b0;
            l_q           <= '0;
            r_q           <= '0;
            v_q           <= 1'b0;
            run_ok_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            div_q         <= div_d;
            cell_q        <= cell_d;
            frame_cnt_q   <= frame_cnt_d;
            spdif_q       <= spdif_d;
            block_start_q <= block_start_d;
            pre_inv_q     <= pre_inv_d;
            l_q           <= l_d;
            r_q           <= r_d;
            v_q           <= v_d;
            run_ok_q      <= 1'b1;
        end
    end

    assign bus.ready_o       = ready;
    assign bus.underrun_o    = ready & ~bus.valid_i;
    assign bus.spdif_o       = spdif_q;
    assign bus.block_start_o = block_start_q;

endmodule

// File: tb/tb_spdif_frame_tx.sv
// Testbench for spdif_frame_tx: a 24-bit, 1-cycle-cell instance for framing, handshake,
// underrun, enable and reset scenarios, and a 16-bit, 4-cycle-cell instance for alignment,
// cell timing and the channel-status slot. The line is decoded back into preambles and slots.
module tb_spdif_frame_tx;

    localparam logic [7:0] PB = 8'b1110_1000;
    localparam logic [7:0] PM = 8'b1110_0010;
    localparam logic [7:0] PW = 8'b1110_0100;
`ifdef SPDIF_TX_CSTAT_EN
    localparam bit CstatOn = 1'b1;
`else
    localparam bit CstatOn = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    spdif_frame_tx_if #(.DATA_W(24)) bus ();
    spdif_frame_tx_if #(.DATA_W(16)) bus2 ();

    spdif_frame_tx #(
        .DATA_W(24), .CELL_DIV(1), .BLOCK_FRAMES(192), .CSTAT(32'h0000_0200)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    spdif_frame_tx #(
        .DATA_W(16), .CELL_DIV(4), .BLOCK_FRAMES(192), .CSTAT(32'h0000_0200)
    ) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    int   checks = 0;
    int   errors = 0;
    logic cells [128];
    logic bsr   [128];
    int   mid_ready;
    int   mid_under;

    // Expected C slot: CSTAT = 32'h200 sets bit 9 only.
    function automatic logic exp_c(input int frame);
        return CstatOn && (frame == 9);
    endfunction

    task automatic apply_reset();
        rst_n = 1'b0;
        bus.en_i = 1'b0;  bus.valid_i = 1'b0;  bus.l_i = '0;  bus.r_i = '0;
        bus2.en_i = 1'b0; bus2.valid_i = 1'b0; bus2.l_i = '0; bus2.r_i = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_ready(output logic ok, output logic under);
        #1;
        ok    = bus.ready_o;
        under = bus.underrun_o;
        for (int i = 0; i < 300 && ok !== 1'b1; i++) begin
            @(negedge clk);
            ok    = bus.ready_o;
            under = bus.underrun_o;
        end
    endtask

    // Records one 128-cell frame; next-frame inputs are applied mid-frame, en_i at en_cell.
    task automatic collect_frame(input logic [23:0] nl, input logic [23:0] nr,
                                 input logic nvalid, input logic nen, input int en_cell,
                                 output logic got_ready, output logic got_under);
        mid_ready = 0;
        mid_under = 0;
        got_ready = 1'b0;
        got_under = 1'b0;
        for (int i = 0; i < 128; i++) begin
            @(negedge clk);
            cells[i] = bus.spdif_o;
            bsr[i]   = bus.block_start_o;
            if (i == 64) begin
                bus.l_i = nl; bus.r_i = nr; bus.valid_i = nvalid;
            end
            if (i == en_cell) bus.en_i = nen;
            if (i < 127) begin
                mid_ready += int'(bus.ready_o);
                mid_under += int'(bus.underrun_o);
            end else begin
                got_ready = bus.ready_o;
                got_under = bus.underrun_o;
            end
        end
    endtask

    task automatic decode_sub(input int base, output logic [7:0] pre, output logic [31:0] w,
                              output int bad);
        pre = '0;
        w   = '0;
        bad = 0;
        for (int k = 0; k < 8; k++) pre = {pre[6:0], cells[base + k]};
        for (int s = 4; s < 32; s++) begin
            if (cells[base + 2 * s] === cells[base + 2 * s - 1]) bad++;
            w[s] = cells[base + 2 * s] ^ cells[base + 2 * s + 1];
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.en_i = 1'b1; bus.valid_i = 1'b1; bus.l_i = '1; bus.r_i = '1;
        bus2.en_i = 1'b0; bus2.valid_i = 1'b0; bus2.l_i = '0; bus2.r_i = '0;
        @(negedge clk);
        checks++; if (bus.spdif_o !== 1'b0) begin errors++;
            $display("FAIL reset_spdif got %b want 0", bus.spdif_o); end
        checks++; if (bus.ready_o !== 1'b0) begin errors++;
            $display("FAIL reset_ready got %b want 0", bus.ready_o); end
        checks++; if (bus.block_start_o !== 1'b0) begin errors++;
            $display("FAIL reset_block_start got %b want 0", bus.block_start_o); end
        checks++; if (bus.underrun_o !== 1'b0) begin errors++;
            $display("FAIL reset_underrun got %b want 0", bus.underrun_o); end
    endtask

    task automatic test_basic();
        logic ok, und, gr, gu;
        logic [7:0] pl, pr;
        logic [31:0] wl, wr;
        int bl, br, nbs;
        apply_reset();
        bus.l_i = 24'h000001; bus.r_i = 24'h000002; bus.valid_i = 1'b1; bus.en_i = 1'b1;
        wait_ready(ok, und);
        checks++; if (ok !== 1'b1) begin errors++;
            $display("FAIL basic_first_ready got %b want 1", ok); end
        collect_frame(24'h000001, 24'h000002, 1'b1, 1'b1, 999, gr, gu);
        decode_sub(0, pl, wl, bl);
        decode_sub(64, pr, wr, br);
        nbs = 0;
        for (int i = 0; i < 128; i++) nbs += int'(bsr[i]);
        checks++; if (pl !== PB) begin errors++;
            $display("FAIL basic_pre_b got %b want %b", pl, PB); end
        checks++; if (bsr[0] !== 1'b1 || nbs != 1) begin errors++;
            $display("FAIL basic_block_start got cell0=%b count=%0d want 1/1", bsr[0], nbs); end
        checks++; if (pr !== PW) begin errors++;
            $display("FAIL basic_pre_w got %b want %b", pr, PW); end
        checks++; if (wl[27:4] !== 24'h000001 || wr[27:4] !== 24'h000002) begin errors++;
            $display("FAIL basic_audio got L=%h R=%h want 1/2", wl[27:4], wr[27:4]); end
        checks++; if (wl[30:28] !== 3'b000 || wr[30:28] !== 3'b000) begin errors++;
            $display("FAIL basic_vuc got %b/%b want 000/000", wl[30:28], wr[30:28]); end
        checks++; if ((^wl[31:4]) !== 1'b0 || (^wr[31:4]) !== 1'b0) begin errors++;
            $display("FAIL basic_parity got %b/%b want 0/0", ^wl[31:4], ^wr[31:4]); end
        checks++; if (bl != 0 || br != 0 || cells[63] !== 1'b0 || cells[127] !== 1'b0) begin
            errors++;
            $display("FAIL basic_bmc got bad=%0d/%0d end=%b/%b want 0/0 0/0", bl, br,
                     cells[63], cells[127]); end
        checks++; if (gr !== 1'b1 || mid_ready != 0) begin errors++;
            $display("FAIL basic_ready_period got end=%b mid=%0d want 1/0", gr, mid_ready); end
        collect_frame(24'h000001, 24'h000002, 1'b1, 1'b1, 999, gr, gu);
        decode_sub(0, pl, wl, bl);
        checks++; if (pl !== PM || bsr[0] !== 1'b0) begin errors++;
            $display("FAIL basic_pre_m got %b bs=%b want %b bs=0", pl, bsr[0], PM); end
    endtask

    task automatic test_block();
        logic ok, und, gr, gu;
        logic [7:0] pl, pr;
        logic [31:0] wl, wr;
        int bl, br, n_b, bad_pre, bad_w, bad_data, bad_c, bad_rdy, bad_bs;
        n_b = 0; bad_pre = 0; bad_w = 0; bad_data = 0; bad_c = 0; bad_rdy = 0; bad_bs = 0;
        apply_reset();
        bus.l_i = 24'd0; bus.r_i = 24'd1; bus.valid_i = 1'b1; bus.en_i = 1'b1;
        wait_ready(ok, und);
        for (int k = 0; k < 384; k++) begin
            collect_frame(24'(2 * (k + 1)), 24'(2 * (k + 1) + 1), 1'b1, 1'b1, 999, gr, gu);
            decode_sub(0, pl, wl, bl);
            decode_sub(64, pr, wr, br);
            if (pl === PB) n_b++;
            if ((k == 0 || k == 192) ? (pl !== PB) : (pl !== PM)) bad_pre++;
            if (pr !== PW) bad_w++;
            if (wl[27:4] !== 24'(2 * k) || wr[27:4] !== 24'(2 * k + 1) || wl[29:28] !== 2'b00
                || wr[29:28] !== 2'b00 || (^wl[31:4]) !== 1'b0 || (^wr[31:4]) !== 1'b0
                || bl != 0 || br != 0 || cells[127] !== 1'b0) bad_data++;
            if (wl[30] !== exp_c(k) || wr[30] !== exp_c(k)) bad_c++;
            if (gr !== 1'b1 || mid_ready != 0) bad_rdy++;
            if (bsr[0] !== ((k % 192) == 0)) bad_bs++;
        end
        checks++; if (n_b != 2) begin errors++;
            $display("FAIL block_b_count got %0d want 2", n_b); end
        checks++; if (bad_pre != 0) begin errors++;
            $display("FAIL block_left_preamble got %0d bad frames want 0", bad_pre); end
        checks++; if (bad_w != 0) begin errors++;
            $display("FAIL block_right_preamble got %0d bad frames want 0", bad_w); end
        checks++; if (bad_data != 0) begin errors++;
            $display("FAIL block_data got %0d bad frames want 0", bad_data); end
        checks++; if (bad_c != 0) begin errors++;
            $display("FAIL block_cstat got %0d bad frames want 0", bad_c); end
        checks++; if (bad_rdy != 0) begin errors++;
            $display("FAIL block_ready got %0d bad frames want 0", bad_rdy); end
        checks++; if (bad_bs != 0) begin errors++;
            $display("FAIL block_start_pulse got %0d bad frames want 0", bad_bs); end
    endtask

    task automatic test_underrun();
        logic ok, und, gr0, gu0, gr1, gu1, gr2, gu2;
        logic [7:0] pl, pr;
        logic [31:0] wl, wr;
        int bl, br, pulses;
        apply_reset();
        bus.l_i = 24'h111111; bus.r_i = 24'h222222; bus.valid_i = 1'b1; bus.en_i = 1'b1;
        wait_ready(ok, und);
        collect_frame(24'hABCDEF, 24'h123456, 1'b0, 1'b1, 999, gr0, gu0);
        pulses = mid_under + int'(gu0);
        collect_frame(24'h654321, 24'h0FEDCB, 1'b1, 1'b1, 999, gr1, gu1);
        pulses += mid_under + int'(gu1);
        decode_sub(0, pl, wl, bl);
        decode_sub(64, pr, wr, br);
        checks++; if (gu0 !== 1'b1 || pulses != 1) begin errors++;
            $display("FAIL underrun_pulse got at_ready=%b total=%0d want 1/1", gu0, pulses); end
        checks++; if (wl[28:4] !== {1'b1, 24'h0} || wr[28:4] !== {1'b1, 24'h0}) begin
            errors++;
            $display("FAIL underrun_frame got L=%h R=%h want V=1 audio=0", wl[28:4], wr[28:4]);
        end
        checks++; if ((^wl[31:4]) !== 1'b0 || bl != 0 || cells[127] !== 1'b0) begin errors++;
            $display("FAIL underrun_parity got par=%b bad=%0d end=%b want 0/0/0",
                     ^wl[31:4], bl, cells[127]); end
        collect_frame(24'h654321, 24'h0FEDCB, 1'b1, 1'b1, 999, gr2, gu2);
        decode_sub(0, pl, wl, bl);
        decode_sub(64, pr, wr, br);
        checks++; if (wl[28:4] !== {1'b0, 24'h654321} || wr[28:4] !== {1'b0, 24'h0FEDCB}) begin
            errors++;
            $display("FAIL underrun_recover got L=%h R=%h want V=0 654321/0fedcb",
                     wl[28:4], wr[28:4]); end
    endtask

    task automatic test_en_drop();
        logic ok, und, gr, gu;
        logic [7:0] pl, pr;
        logic [31:0] wl, wr;
        int bl, br, idle_bad;
        apply_reset();
        bus.l_i = 24'h0000AA; bus.r_i = 24'h0000BB; bus.valid_i = 1'b1; bus.en_i = 1'b1;
        wait_ready(ok, und);
        collect_frame(24'h0000CC, 24'h0000DD, 1'b1, 1'b1, 999, gr, gu);
        collect_frame(24'h0000EE, 24'h0000FF, 1'b1, 1'b0, 18, gr, gu);
        decode_sub(0, pl, wl, bl);
        decode_sub(64, pr, wr, br);
        checks++; if (gr !== 1'b0) begin errors++;
            $display("FAIL en_drop_no_ready got %b want 0", gr); end
        checks++; if (pr !== PW || wl[27:4] !== 24'h0000CC || wr[27:4] !== 24'h0000DD
                      || br != 0) begin errors++;
            $display("FAIL en_drop_complete got pre=%b L=%h R=%h want %b cc/dd",
                     pr, wl[27:4], wr[27:4], PW); end
        idle_bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.spdif_o !== 1'b0 || bus.ready_o !== 1'b0) idle_bad++;
        end
        checks++; if (cells[127] !== 1'b0 || idle_bad != 0) begin errors++;
            $display("FAIL en_drop_idle got end=%b bad=%0d want 0/0", cells[127], idle_bad); end
        bus.en_i = 1'b1;
        wait_ready(ok, und);
        collect_frame(24'h0000EE, 24'h0000FF, 1'b1, 1'b1, 999, gr, gu);
        decode_sub(0, pl, wl, bl);
        checks++; if (ok !== 1'b1 || pl !== PM || bsr[0] !== 1'b0) begin errors++;
            $display("FAIL en_drop_resume got rdy=%b pre=%b bs=%b want 1 %b 0", ok, pl,
                     bsr[0], PM); end
    endtask

    task automatic test_reset_mid();
        logic ok, und, gr, gu, found;
        logic [7:0] pl;
        logic [31:0] wl;
        int bl;
        apply_reset();
        bus.l_i = 24'h0; bus.r_i = 24'hFFFFFF; bus.valid_i = 1'b1; bus.en_i = 1'b1;
        wait_ready(ok, und);
        collect_frame(24'h0, 24'hFFFFFF, 1'b1, 1'b1, 999, gr, gu);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (i >= 80 && bus.spdif_o === 1'b1) found = 1'b1;
        end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (found !== 1'b1 || bus.spdif_o !== 1'b0 || bus.ready_o !== 1'b0
                      || bus.block_start_o !== 1'b0 || bus.underrun_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_clear got hi_seen=%b spdif=%b rdy=%b bs=%b und=%b want 1 0000",
                     found, bus.spdif_o, bus.ready_o, bus.block_start_o, bus.underrun_o); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_ready(ok, und);
        collect_frame(24'h0, 24'hFFFFFF, 1'b1, 1'b1, 999, gr, gu);
        decode_sub(0, pl, wl, bl);
        checks++; if (ok !== 1'b1 || pl !== PB || bsr[0] !== 1'b1) begin errors++;
            $display("FAIL reset_mid_restart got rdy=%b pre=%b bs=%b want 1 %b 1", ok, pl,
                     bsr[0], PB); end
    endtask

    task automatic test_cell_div();
        logic ok, gr;
        logic [7:0] pl, pr;
        logic [31:0] wl, wr;
        int bl, br, hold_bad, bad_c, bad_data, bad_rdy, rdy_mid, nbs;
        hold_bad = 0; bad_c = 0; bad_data = 0; bad_rdy = 0;
        apply_reset();
        bus2.l_i = 16'h8001; bus2.r_i = 16'h00FF; bus2.valid_i = 1'b1; bus2.en_i = 1'b1;
        #1;
        ok = bus2.ready_o;
        for (int i = 0; i < 20 && ok !== 1'b1; i++) begin
            @(negedge clk);
            ok = bus2.ready_o;
        end
        checks++; if (ok !== 1'b1) begin errors++;
            $display("FAIL div4_first_ready got %b want 1", ok); end
        for (int f = 0; f < 11; f++) begin
            rdy_mid = 0; gr = 1'b0; nbs = 0;
            for (int j = 0; j < 512; j++) begin
                @(negedge clk);
                if (j % 4 == 0) cells[j / 4] = bus2.spdif_o;
                else if (bus2.spdif_o !== cells[j / 4]) hold_bad++;
                nbs += int'(bus2.block_start_o);
                if (j < 511) rdy_mid += int'(bus2.ready_o);
                else         gr = bus2.ready_o;
            end
            decode_sub(0, pl, wl, bl);
            decode_sub(64, pr, wr, br);
            if (f == 0) begin
                checks++; if (wl[27:4] !== 24'h800100 || wr[27:4] !== 24'h00FF00) begin
                    errors++;
                    $display("FAIL div4_align got L=%h R=%h want 800100/00ff00",
                             wl[27:4], wr[27:4]); end
                checks++; if (wl[11:4] !== 8'h00 || wr[11:4] !== 8'h00) begin errors++;
                    $display("FAIL div4_low_slots got %h/%h want 00/00", wl[11:4], wr[11:4]);
                end
                checks++; if (pl !== PB || nbs != 1) begin errors++;
                    $display("FAIL div4_pre_b got %b bs_cycles=%0d want %b 1", pl, nbs, PB); end
            end
            if (wl[30] !== exp_c(f) || wr[30] !== exp_c(f)) bad_c++;
            if ((^wl[31:4]) !== 1'b0 || (^wr[31:4]) !== 1'b0 || bl != 0 || br != 0
                || pr !== PW || cells[127] !== 1'b0) bad_data++;
            if (gr !== 1'b1 || rdy_mid != 0) bad_rdy++;
        end
        checks++; if (hold_bad != 0) begin errors++;
            $display("FAIL div4_cell_hold got %0d glitches want 0", hold_bad); end
        checks++; if (bad_c != 0) begin errors++;
            $display("FAIL div4_cstat got %0d bad frames want 0", bad_c); end
        checks++; if (bad_data != 0 || bad_rdy != 0) begin errors++;
            $display("FAIL div4_frames got data=%0d ready=%0d bad want 0/0", bad_data, bad_rdy);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_block();
        test_underrun();
        test_en_drop();
        test_reset_mid();
        test_cell_div();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
